cache_ctrl: RTL

Clocked initiator FSM that drives the 16-set, 4-word-line cache block over its enable/ack four-phase handshake. It sits between the CPU and the cache.
- Serves CPU word reads and writes.
- Runs the write-back / write-allocate miss sequence against word-granular main memory.
- Runs the cache-wide reset operation after rst.

---
 rtl/cache_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Cache controller: serves CPU word accesses through a 16-set, 4-word-line write-back cache,
// running write-back / write-allocate miss sequences against word-granular main memory.
module cache_ctrl #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned WRD_W  = 2,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned ADDR_W = TAG_W + IDX_W + WRD_W
) (
  input  logic              clk,
  input  logic              rst,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  // cache side
  output logic              c_enable,
  output logic              c_rst,
  output logic [IDX_W-1:0]  c_index,
  output logic [WRD_W-1:0]  c_word,
  output logic              c_comp,
  output logic              c_write,
  output logic [TAG_W-1:0]  c_tag,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_valid,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_vld,
  input  logic              c_ack,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    StInit, StIdle, StLookup, StWbCache, StWbMem, StFillMem, StFillCache
  } state_e;

  // Four-phase cache handshake: wait for ack low, hold enable until ack, wait for release.
  typedef enum logic [1:0] {CpWait, CpReq, CpRel} cphase_e;

  state_e            state;
  cphase_e           cph;
  logic [WRD_W-1:0]  k;

  logic              req_we;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WRD_W-1:0]  req_word;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  victim_tag;

  logic              cap_hit, cap_dirty, cap_vld;
  logic [TAG_W-1:0]  cap_tag;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] mem_word;

  logic c_access, mem_access;
  logic c_launch, c_got, c_done;
  logic m_launch, m_done;

  logic              f_rst, f_comp, f_write, f_valid;
  logic [IDX_W-1:0]  f_index;
  logic [WRD_W-1:0]  f_word;
  logic [TAG_W-1:0]  f_tag;
  logic [DATA_W-1:0] f_wdata;
  logic [ADDR_W-1:0] m_addr;

  always_comb begin
    c_access   = (state == StInit) || (state == StLookup) ||
                 (state == StWbCache) || (state == StFillCache);
    mem_access = (state == StWbMem) || (state == StFillMem);
    // IDLE launches the lookup straight from the CPU inputs to save a cycle on hits.
    c_launch   = (cph == CpWait) && !c_ack && (c_access || (state == StIdle && cpu_req));
    c_got      = (cph == CpReq) && c_ack;
    c_done     = (cph == CpRel) && !c_ack;
    m_launch   = mem_access && !mem_req;
    m_done     = mem_access && mem_req && mem_ack;
  end

  always_comb begin
    f_rst   = 1'b0;
    f_comp  = 1'b0;
    f_write = 1'b0;
    f_valid = 1'b0;
    f_index = req_idx;
    f_word  = k;
    f_tag   = req_tag;
    f_wdata = mem_word;
    unique case (state)
      StInit: f_rst = 1'b1;
      StIdle: begin
        f_comp  = 1'b1;
        f_write = cpu_we;
        f_valid = 1'b1;
        f_index = cpu_addr[WRD_W +: IDX_W];
        f_word  = cpu_addr[WRD_W-1:0];
        f_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
        f_wdata = cpu_wdata;
      end
      StLookup: begin
        f_comp  = 1'b1;
        f_write = req_we;
        f_valid = 1'b1;
        f_word  = req_word;
        f_wdata = req_wdata;
      end
      StWbCache: f_tag = victim_tag;
      StFillCache: begin
        f_write = 1'b1;
        f_valid = 1'b1;
      end
      StWbMem, StFillMem: ;
    endcase
  end

  always_comb begin
    m_addr = {req_tag, req_idx, k};
    if (state == StWbMem) m_addr = {victim_tag, req_idx, k};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StInit;
      cph        <= CpWait;
      k          <= '0;
      req_we     <= 1'b0;
      req_tag    <= '0;
      req_idx    <= '0;
      req_word   <= '0;
      req_wdata  <= '0;
      victim_tag <= '0;
      cap_hit    <= 1'b0;
      cap_dirty  <= 1'b0;
      cap_vld    <= 1'b0;
      cap_tag    <= '0;
      cap_data   <= '0;
      mem_word   <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      busy       <= 1'b0;
      c_enable   <= 1'b0;
      c_rst      <= 1'b0;
      c_index    <= '0;
      c_word     <= '0;
      c_comp     <= 1'b0;
      c_write    <= 1'b0;
      c_tag      <= '0;
      c_wdata    <= '0;
      c_valid    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      busy      <= 1'b1;

      if (c_launch) begin
        c_enable <= 1'b1;
        c_rst    <= f_rst;
        c_index  <= f_index;
        c_word   <= f_word;
        c_comp   <= f_comp;
        c_write  <= f_write;
        c_tag    <= f_tag;
        c_wdata  <= f_wdata;
        c_valid  <= f_valid;
        cph      <= CpReq;
      end else if (c_got) begin
        c_enable  <= 1'b0;
        c_rst     <= 1'b0;
        cap_hit   <= c_hit;
        cap_dirty <= c_dirty;
        cap_vld   <= c_vld;
        cap_tag   <= c_tag_out;
        cap_data  <= c_rdata;
        cph       <= CpRel;
      end else if (c_done) begin
        cph <= CpWait;
      end

      if (m_launch) begin
        mem_req   <= 1'b1;
        mem_we    <= (state == StWbMem);
        mem_addr  <= m_addr;
        mem_wdata <= cap_data;
      end else if (m_done) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        mem_word <= mem_rdata;
      end

      unique case (state)
        StInit: begin
          if (c_done) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        StIdle: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
            req_idx   <= cpu_addr[WRD_W +: IDX_W];
            req_word  <= cpu_addr[WRD_W-1:0];
            req_wdata <= cpu_wdata;
            state     <= StLookup;
          end else begin
            busy <= 1'b0;
          end
        end
        StLookup: begin
          if (c_done) begin
            if (cap_hit) begin
              cpu_ready <= 1'b1;
              if (!req_we) cpu_rdata <= cap_data;
              busy  <= 1'b0;
              state <= StIdle;
            end else if (cap_vld && cap_dirty) begin
              victim_tag <= cap_tag;
              state      <= StWbCache;
            end else begin
              state <= StFillMem;
            end
          end
        end
        StWbCache: begin
          if (c_done) state <= StWbMem;
        end
        StWbMem: begin
          if (m_done) begin
            k     <= k + 1'b1;
            state <= (&k) ? StFillMem : StWbCache;
          end
        end
        StFillMem: begin
          if (m_done) state <= StFillCache;
        end
        StFillCache: begin
          if (c_done) begin
            k     <= k + 1'b1;
            state <= (&k) ? StLookup : StFillMem;
          end
        end
      endcase
    end
  end

endmodule
